// File: rtl/frame_unpacker_80m.sv
// Receive-side link frame unpacker: hunts for SYNC, collects 56-bit frames MSB-first,
// checks CRC8 over {CNT, DATA} and publishes good samples with counter-gap detection.
module frame_unpacker_80m #(
  parameter logic [7:0] SYNC_BYTE = 8'hA5,
  parameter logic [7:0] CRC_POLY  = 8'h07,
  parameter logic [7:0] CRC_INIT  = 8'h00
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx_bit,
  input  logic        rx_bit_valid,
  output logic [31:0] sample_data,
  output logic [7:0]  sample_cnt,
  output logic        sample_valid,
  output logic        crc_err,
  output logic        cnt_gap,
  output logic        locked,
  output logic [15:0] crc_err_cnt
);

  typedef enum logic {S_HUNT, S_RECV} state_t;

  state_t      state, state_next;
  logic [7:0]  window;
  logic [3:0]  fill;
  logic [5:0]  bit_cnt;
  logic [46:0] payload;
  logic [7:0]  last_cnt;

  logic [7:0]  win_shift;
  logic        sync_hit;
  logic        last_bit;
  logic [47:0] frame_word;
  logic        crc_ok;

  // MSB-first CRC8 over {CNT, DATA}, no reflection, no final XOR.
  function automatic logic [7:0] crc8(input logic [39:0] d);
    logic [7:0]  c;
    logic [39:0] sh;
    c  = CRC_INIT;
    sh = d;
    for (int unsigned i = 0; i < 40; i++) begin
      if (c[7] ^ sh[39]) c = (c << 1) ^ CRC_POLY;
      else               c = c << 1;
      sh = sh << 1;
    end
    return c;
  endfunction

  // The fill guard keeps the cleared window from matching a SYNC of all zeros.
  assign win_shift  = {window[6:0], rx_bit};
  assign sync_hit   = (fill >= 4'd7) && (win_shift == SYNC_BYTE);
  assign last_bit   = (bit_cnt == 6'd47);
  assign frame_word = {payload, rx_bit};
  assign crc_ok     = (crc8(frame_word[47:8]) == frame_word[7:0]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_HUNT;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_HUNT: if (rx_bit_valid && sync_hit) state_next = S_RECV;
      S_RECV: if (rx_bit_valid && last_bit) state_next = S_HUNT;
      default: state_next = S_HUNT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      window       <= '0;
      fill         <= '0;
      bit_cnt      <= '0;
      payload      <= '0;
      last_cnt     <= '0;
      sample_data  <= '0;
      sample_cnt   <= '0;
      sample_valid <= 1'b0;
      crc_err      <= 1'b0;
      cnt_gap      <= 1'b0;
      locked       <= 1'b0;
      crc_err_cnt  <= '0;
    end else begin
      sample_valid <= 1'b0;
      crc_err      <= 1'b0;
      cnt_gap      <= 1'b0;
      if (rx_bit_valid) begin
        case (state)
          S_HUNT: begin
            window <= win_shift;
            if (fill != 4'd8) fill <= fill + 4'd1;
            if (sync_hit) bit_cnt <= '0;
          end
          S_RECV: begin
            payload <= frame_word[46:0];
            bit_cnt <= bit_cnt + 6'd1;
            if (last_bit) begin
              // Restart the hunt from scratch so a bad frame's bits are never re-scanned.
              window <= '0;
              fill   <= '0;
              if (crc_ok) begin
                sample_valid <= 1'b1;
                sample_data  <= frame_word[39:8];
                sample_cnt   <= frame_word[47:40];
                cnt_gap      <= locked && (frame_word[47:40] != last_cnt + 8'd1);
                last_cnt     <= frame_word[47:40];
                locked       <= 1'b1;
              end else begin
                crc_err <= 1'b1;
                locked  <= 1'b0;
                if (crc_err_cnt != '1) crc_err_cnt <= crc_err_cnt + 16'd1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
